// File: rtl/mem_line_server_pkg.sv
// rtl/mem_line_server_pkg.sv - shared processor width constants plus memory depth and latency
package mem_line_server_pkg;

  localparam int ARCH_BITS        = 32;
  localparam int MEMORY_LINE_BITS = 128;
  localparam int MEM_LINES        = 1024;
  localparam int LATENCY          = 10;
  localparam int IDX_BITS         = $clog2(MEM_LINES);
  localparam int OFF_BITS         = $clog2(MEMORY_LINE_BITS / 8);

endpackage

// File: rtl/mem_line_array.sv
// rtl/mem_line_array.sv - single-port line storage, synchronous write, registered read
module mem_line_array
  import mem_line_server_pkg::*;
#(
  parameter int LINE_W = MEMORY_LINE_BITS,
  parameter int DEPTH  = MEM_LINES,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wline,
  output logic [LINE_W-1:0] rline
);

  // Contents are deliberately not reset; the environment preloads them.
  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wline;
    if (re) rline <= mem[idx];
  end

endmodule

// File: rtl/mem_line_server.sv
// rtl/mem_line_server.sv - arbitrates I-fill, D-fill and write-back requests onto one line array
module mem_line_server #(
  parameter int ARCH_BITS        = mem_line_server_pkg::ARCH_BITS,
  parameter int MEMORY_LINE_BITS = mem_line_server_pkg::MEMORY_LINE_BITS,
  parameter int MEM_LINES        = mem_line_server_pkg::MEM_LINES,
  parameter int IDX_BITS         = $clog2(MEM_LINES),
  parameter int OFF_BITS         = $clog2(MEMORY_LINE_BITS / 8),
  parameter int LATENCY          = mem_line_server_pkg::LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iReadReq,
  input  logic [ARCH_BITS-1:0]        iReadAddr,
  output logic [MEMORY_LINE_BITS-1:0] iReadData,
  output logic                        iReadValid,
  input  logic                        dReadReq,
  input  logic [ARCH_BITS-1:0]        dReadAddr,
  output logic [MEMORY_LINE_BITS-1:0] dReadData,
  output logic                        dReadValid,
  input  logic                        wReq,
  input  logic [ARCH_BITS-1:0]        wAddr,
  input  logic [MEMORY_LINE_BITS-1:0] wLine,
  output logic                        wAck
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {REQ_W, REQ_D, REQ_I} req_id_t;

  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                      state, state_nx;
  req_id_t                     owner, grant_id;
  logic [CNT_BITS-1:0]         cnt, cnt_nx;
  logic [IDX_BITS-1:0]         idx_q, grant_idx, i_idx, d_idx, w_idx, acc_idx;
  logic [MEMORY_LINE_BITS-1:0] wline_q, acc_wline, arr_rline, i_hold, d_hold;
  logic                        any_req, access, acc_write, arr_we, arr_re;
  logic                        resp_i, resp_d, resp_w;
  logic                        unused_addr_bits;

  assign i_idx = iReadAddr[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign d_idx = dReadAddr[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign w_idx = wAddr[OFF_BITS+IDX_BITS-1:OFF_BITS];
  assign unused_addr_bits = ^{iReadAddr[OFF_BITS-1:0], iReadAddr[ARCH_BITS-1:OFF_BITS+IDX_BITS],
                              dReadAddr[OFF_BITS-1:0], dReadAddr[ARCH_BITS-1:OFF_BITS+IDX_BITS],
                              wAddr[OFF_BITS-1:0], wAddr[ARCH_BITS-1:OFF_BITS+IDX_BITS]};

  assign any_req = wReq | dReadReq | iReadReq;

  // Fixed priority: write-back beats data fill beats instruction fill.
  always_comb begin
    grant_id  = REQ_I;
    grant_idx = i_idx;
    if (dReadReq) begin
      grant_id  = REQ_D;
      grant_idx = d_idx;
    end
    if (wReq) begin
      grant_id  = REQ_W;
      grant_idx = w_idx;
    end
  end

  // The array is accessed on the edge that enters RESP; with a one-cycle latency
  // that is the grant edge itself, so the live request fields are used.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    access    = 1'b0;
    acc_write = (owner == REQ_W);
    acc_idx   = idx_q;
    acc_wline = wline_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (LATENCY == 1) begin
            state_nx  = RESP;
            cnt_nx    = '0;
            access    = 1'b1;
            acc_write = (grant_id == REQ_W);
            acc_idx   = grant_idx;
            acc_wline = wLine;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_BITS'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - CNT_BITS'(1);
        if (cnt == CNT_BITS'(1)) begin
          access   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= REQ_W;
      idx_q   <= '0;
      wline_q <= '0;
      i_hold  <= '0;
      d_hold  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && any_req) begin
        owner <= grant_id;
        idx_q <= grant_idx;
        if (grant_id == REQ_W) wline_q <= wLine;
      end
      if (resp_i) i_hold <= arr_rline;
      if (resp_d) d_hold <= arr_rline;
    end
  end

  // Gate with reset so requests held during reset never touch the array.
  assign arr_we = access & acc_write & rst;
  assign arr_re = access & ~acc_write & rst;

  mem_line_array #(
    .LINE_W (MEMORY_LINE_BITS),
    .DEPTH  (MEM_LINES),
    .IDX_W  (IDX_BITS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (acc_idx),
    .wline (acc_wline),
    .rline (arr_rline)
  );

  assign resp_i = (state == RESP) && (owner == REQ_I);
  assign resp_d = (state == RESP) && (owner == REQ_D);
  assign resp_w = (state == RESP) && (owner == REQ_W);

  assign iReadValid = resp_i;
  assign dReadValid = resp_d;
  assign wAck       = resp_w;
  assign iReadData  = resp_i ? arr_rline : i_hold;
  assign dReadData  = resp_d ? arr_rline : d_hold;

endmodule

// File: tb/tb_mem_line_server.sv
// tb/tb_mem_line_server.sv - table, directed and random checks of mem_line_server
module tb_mem_line_server;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         i_req, d_req, w_req, i_valid, d_valid, w_ack;
  logic [31:0]  i_addr, d_addr, w_addr;
  logic [127:0] w_line, i_data, d_data;
  logic         i1_req, d1_req, w1_req, i1_valid, d1_valid, w1_ack;
  logic [31:0]  i1_addr, d1_addr, w1_addr;
  logic [127:0] w1_line, i1_data, d1_data;

  mem_line_server dut (
    .clk(clk), .rst(rst),
    .iReadReq(i_req), .iReadAddr(i_addr), .iReadData(i_data), .iReadValid(i_valid),
    .dReadReq(d_req), .dReadAddr(d_addr), .dReadData(d_data), .dReadValid(d_valid),
    .wReq(w_req), .wAddr(w_addr), .wLine(w_line), .wAck(w_ack)
  );

  mem_line_server #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .iReadReq(i1_req), .iReadAddr(i1_addr), .iReadData(i1_data), .iReadValid(i1_valid),
    .dReadReq(d1_req), .dReadAddr(d1_addr), .dReadData(d1_data), .dReadValid(d1_valid),
    .wReq(w1_req), .wAddr(w1_addr), .wLine(w1_line), .wAck(w1_ack)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0, n_mis = 0;
  int ni = 0, nd = 0, nw = 0, n1i = 0, n1d = 0, n1w = 0;
  logic [127:0] cap_i, cap_d, cap1_i, cap1_d;

  always @(negedge clk) begin
    if (i_valid)  begin ni++;  cap_i  = i_data;  end
    if (d_valid)  begin nd++;  cap_d  = d_data;  end
    if (w_ack)    nw++;
    if (i1_valid) begin n1i++; cap1_i = i1_data; end
    if (d1_valid) begin n1d++; cap1_d = d1_data; end
    if (w1_ack)   n1w++;
  end

  logic [127:0] ref_mem [1024];

  typedef struct {
    string        name;
    int           kind;     // 0 = I fill, 1 = D fill, 2 = write-back
    logic [31:0]  addr;
    logic [127:0] line;
    logic [127:0] exp_data;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lidx(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  function automatic int own_cnt(input int kind);
    return (kind == 0) ? ni : (kind == 1) ? nd : nw;
  endfunction

  function automatic int own1_cnt(input int kind);
    return (kind == 0) ? n1i : (kind == 1) ? n1d : n1w;
  endfunction

  task automatic set_req(input int kind, input logic v, input logic [31:0] a, input logic [127:0] l);
    case (kind)
      0: begin i_req = v; i_addr = a; end
      1: begin d_req = v; d_addr = a; end
      default: begin w_req = v; w_addr = a; w_line = l; end
    endcase
  endtask

  task automatic set_req1(input int kind, input logic v, input logic [31:0] a, input logic [127:0] l);
    case (kind)
      0: begin i1_req = v; i1_addr = a; end
      1: begin d1_req = v; d1_addr = a; end
      default: begin w1_req = v; w1_addr = a; w1_line = l; end
    endcase
  endtask

  // One request on the LATENCY=10 server; address/data are scrambled after grant.
  task automatic do_req(input string nm, input int kind, input logic [31:0] a,
                        input logic [127:0] l, input logic [127:0] exp, input bit drop_early);
    int t0, own0, tot0, lat;
    bit seen;
    own0 = own_cnt(kind);
    tot0 = ni + nd + nw;
    seen = 1'b0;
    lat  = -1;
    set_req(kind, 1'b1, a, l);
    t0 = cyc;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (own_cnt(kind) != own0) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end else begin
        if (k == 1) set_req(kind, 1'b1, $urandom, {4{$urandom}});
        if (drop_early && k == 2) set_req(kind, 1'b0, $urandom, {4{$urandom}});
      end
    end
    set_req(kind, 1'b0, $urandom, {4{$urandom}});
    chk({nm, " latency"}, 128'(lat), 128'(10));
    if (kind != 2) chk({nm, " data"}, (kind == 0) ? cap_i : cap_d, exp);
    repeat (3) @(negedge clk);
    #1;
    chk({nm, " own pulses"}, 128'(own_cnt(kind) - own0), 128'(1));
    chk({nm, " other pulses"}, 128'((ni + nd + nw - tot0) - (own_cnt(kind) - own0)), 128'(0));
  endtask

  // One request on the LATENCY=1 server; req is held one cycle past the pulse.
  task automatic req1(input string nm, input int kind, input logic [31:0] a,
                      input logic [127:0] l, input logic [127:0] exp);
    int t0, own0, lat;
    bit seen;
    own0 = own1_cnt(kind);
    seen = 1'b0;
    lat  = -1;
    set_req1(kind, 1'b1, a, l);
    t0 = cyc;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk); #1;
      if (own1_cnt(kind) != own0) begin
        seen = 1'b1;
        lat  = cyc - t0;
      end
    end
    @(negedge clk); #1;
    set_req1(kind, 1'b0, 32'h0, 128'h0);
    chk({nm, " latency"}, 128'(lat), 128'(1));
    if (kind != 2) chk({nm, " data"}, (kind == 0) ? cap1_i : cap1_d, exp);
    repeat (4) @(negedge clk);
    #1;
    chk({nm, " pulses"}, 128'(own1_cnt(kind) - own0), 128'(1));
  endtask

  vec_t vecs[$];
  logic [127:0] pat_a5, pat_77, pat_ff, pat_12, pat_de, pat_x, pat_cafe, v;
  int t0, t1, tw, td, ti, w0, i0, d0, lat;
  bit fin;

  initial begin
    pat_a5   = {16{8'hA5}};
    pat_77   = {16{8'h77}};
    pat_ff   = {16{8'hFF}};
    pat_12   = {4{32'h12345678}};
    pat_de   = {4{32'hDEADBEEF}};
    pat_x    = {4{32'h0BADF00D}};
    pat_cafe = {4{32'hCAFEF00D}};

    rst = 1'b0;
    i_req = 0; d_req = 0; w_req = 0; i_addr = 0; d_addr = 0; w_addr = 0; w_line = 0;
    i1_req = 0; d1_req = 0; w1_req = 0; i1_addr = 0; d1_addr = 0; w1_addr = 0; w1_line = 0;

    for (int i = 0; i < 1024; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = v;
      dut.u_array.mem[i] = v;
    end
    ref_mem[5] = pat_a5; dut.u_array.mem[5] = pat_a5;
    ref_mem[7] = pat_77; dut.u_array.mem[7] = pat_77;
    dut1.u_array.mem[5] = pat_a5;
    dut1.u_array.mem[9] = 128'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset iReadValid", 128'(i_valid), 128'(0));
    chk("reset dReadValid", 128'(d_valid), 128'(0));
    chk("reset wAck", 128'(w_ack), 128'(0));
    chk("reset iReadData", i_data, 128'h0);
    chk("reset dReadData", d_data, 128'h0);
    chk("reset L1 iReadData", i1_data, 128'h0);
    rst = 1'b1;
    @(negedge clk); #1;

    vecs.push_back('{"i_line5",      0, 32'h0000_0050, 128'h0,  pat_a5});
    vecs.push_back('{"w_line6",      2, 32'h0000_0060, pat_12,  128'h0});
    vecs.push_back('{"d_off_ignored",1, 32'h0000_006C, 128'h0,  pat_12});
    vecs.push_back('{"d_wrap",       1, 32'h0000_4050, 128'h0,  pat_a5});
    vecs.push_back('{"w_line1023",   2, 32'h0000_3FF8, pat_de,  128'h0});
    vecs.push_back('{"i_high_wrap",  0, 32'hFFFF_FFF0, 128'h0,  pat_de});
    vecs.push_back('{"i_line6",      0, 32'h0000_0064, 128'h0,  pat_12});
    foreach (vecs[n]) begin
      do_req(vecs[n].name, vecs[n].kind, vecs[n].addr, vecs[n].line, vecs[n].exp_data, 1'b0);
      if (vecs[n].kind == 2) ref_mem[lidx(vecs[n].addr)] = vecs[n].line;
    end

    // All three requesters at once: W, then D, then I, 11 cycles apart.
    w0 = nw; d0 = nd; i0 = ni;
    tw = -1; td = -1; ti = -1;
    w_req = 1; w_addr = 32'h200; w_line = pat_x;
    d_req = 1; d_addr = 32'h204;
    i_req = 1; i_addr = 32'h4208;
    t0 = cyc;
    fin = 1'b0;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge clk); #1;
      if (tw < 0 && nw != w0) begin tw = cyc - t0; w_req = 0; end
      if (td < 0 && nd != d0) begin td = cyc - t0; d_req = 0; end
      if (ti < 0 && ni != i0) begin ti = cyc - t0; i_req = 0; end
      fin = (tw >= 0) && (td >= 0) && (ti >= 0);
    end
    w_req = 0; d_req = 0; i_req = 0;
    ref_mem[lidx(32'h200)] = pat_x;
    repeat (3) @(negedge clk);
    #1;
    chk("all3 w time", 128'(tw), 128'(10));
    chk("all3 d time", 128'(td), 128'(21));
    chk("all3 i time", 128'(ti), 128'(32));
    chk("all3 d data", cap_d, pat_x);
    chk("all3 i data", cap_i, pat_x);
    chk("all3 pulse counts", 128'((nw - w0) + (nd - d0) * 16 + (ni - i0) * 256), 128'(1 + 16 + 256));

    // Reset three cycles into a write of line 7.
    set_req(2, 1'b1, 32'h70, pat_ff);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    w0 = nw;
    chk("rst wAck", 128'(w_ack), 128'(0));
    chk("rst iReadData", i_data, 128'h0);
    chk("rst dReadData", d_data, 128'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst no ack", 128'(nw - w0), 128'(0));
    chk("rst line7 kept", dut.u_array.mem[7], pat_77);
    rst = 1'b1;
    t1 = cyc;
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk); #1;
      if (nw != w0) lat = cyc - t1;
    end
    set_req(2, 1'b0, 32'h0, 128'h0);
    ref_mem[7] = pat_ff;
    repeat (3) @(negedge clk);
    #1;
    chk("rst regrant latency", 128'(lat), 128'(10));
    chk("rst regrant ack count", 128'(nw - w0), 128'(1));
    do_req("rd_line7", 1, 32'h7C, 128'h0, pat_ff, 1'b0);

    // A write whose req drops during BUSY still commits.
    do_req("w_drop_early", 2, 32'h330, pat_cafe, 128'h0, 1'b1);
    ref_mem[lidx(32'h330)] = pat_cafe;
    do_req("r_after_drop", 0, 32'h8330, 128'h0, pat_cafe, 1'b0);

    // Random traffic against the reference array.
    for (int r = 0; r < 30; r++) begin
      int kind;
      logic [31:0] a;
      logic [127:0] l;
      kind = $urandom_range(0, 2);
      a = ($urandom << 14) | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
      l = {$urandom, $urandom, $urandom, $urandom};
      do_req($sformatf("rand%0d", r), kind, a, l, ref_mem[lidx(a)], ($urandom_range(0, 3) == 0));
      if (kind == 2) ref_mem[lidx(a)] = l;
    end

    // LATENCY=1 build.
    req1("l1_i_line5", 0, 32'h50, 128'h0, pat_a5);
    req1("l1_w_line9", 2, 32'h90, pat_cafe, 128'h0);
    req1("l1_d_line9", 1, 32'h9C, 128'h0, pat_cafe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_line_server.md
# mem_line_server

Line-granular main-memory responder: the memory end of the cache miss/eviction protocol. It serves instruction-cache line fills, data-side line fills and store-buffer line write-backs from one backing array. It arbitrates among the three requesters, models a fixed access latency, and answers each request with a one-cycle valid/ack pulse. It sits at processor top level, below `cacheIns` and `stb`/`dataCache`.

## Interface
- `ARCH_BITS`, proc.ARCH_BITS (32): address and word width.
- `MEMORY_LINE_BITS`, proc.MEMORY_LINE_BITS (128): line width.
- `MEM_LINES`, 1024: backing array depth in lines, power of two.
- `IDX_BITS`, 10: log2(MEM_LINES).
- `OFF_BITS`, 4: log2(MEMORY_LINE_BITS/8), the byte offset within a line.
- `LATENCY`, 10: cycles from request sample to response; must be ≥1.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `iReadReq` in 1: instruction line-fill request, level-held.
- `iReadAddr` in ARCH_BITS: byte address of the instruction line.
- `iReadData` out MEMORY_LINE_BITS: returned instruction line.
- `iReadValid` out 1: one-cycle pulse; `iReadData` is valid.
- `dReadReq` in 1: data line-fill request, level-held.
- `dReadAddr` in ARCH_BITS: byte address of the data line.
- `dReadData` out MEMORY_LINE_BITS: returned data line.
- `dReadValid` out 1: one-cycle pulse.
- `wReq` in 1: line write-back request, level-held.
- `wAddr` in ARCH_BITS: byte address of the line to write.
- `wLine` in MEMORY_LINE_BITS: line data to write.
- `wAck` out 1: one-cycle pulse; the write is committed.

## Operation
- Line index = `addr[OFF_BITS+IDX_BITS-1:OFF_BITS]`. Low offset bits are ignored. Upper bits are ignored, so addresses wrap modulo MEM_LINES.
- The FSM has three states: IDLE, BUSY, RESP.
  - IDLE: if any request is high at a posedge, grant one with fixed priority `wReq` > `dReadReq` > `iReadReq`. Latch the winner's ID, index, and `wLine` for writes. Load the counter with LATENCY-1. Go to BUSY, or straight to RESP when LATENCY==1.
  - BUSY: decrement the counter each cycle. At 0, perform the access: a read captures `array[idx]` into the winner's data register; a write stores the latched line. Then go to RESP.
  - RESP: assert exactly the winner's valid or ack for one cycle, then return to IDLE.
- Requesters hold req until they see valid/ack, and drop it by the next cycle. Entering IDLE after RESP gives a natural one-cycle gap, so a stale req is never re-granted.
- Requests are not preempted. Losers simply stay pending.
- A req that drops during BUSY is still completed: a write is committed, and the pulse is still issued.
- Inputs are latched at grant, so address or data changes after grant have no effect.
- Read after write to the same line returns the new data, because accesses are serialized.
- `iReadData` and `dReadData` hold their last value until the next response to that port.
- Array contents are not reset. The bench preloads them hierarchically or via `$readmemh`.

## Timing
- Request sampled at posedge t (FSM in IDLE) → valid/ack high during cycle t+LATENCY.
  - Minimum period between back-to-back grants is LATENCY+1 cycles.
- Write commit happens at the edge entering RESP. A read granted afterwards sees the new data.
- Reset values: state IDLE, counter 0, `iReadValid`/`dReadValid`/`wAck` 0, `iReadData`/`dReadData` 0.
- Reset asserted mid-operation aborts immediately:
  - The in-flight write is not committed.
  - No pulse is issued.
  - After release, requests still held are re-arbitrated from IDLE.

## Structure
- Width constants stay in the shared `proc` parameter set (ARCH_BITS, MEMORY_LINE_BITS). Add MEM_LINES and LATENCY there too, so the caches and the bench agree.
- Requester IDs (W, D, I) and state encodings are localparams in this block.
- One sub-module: `mem_line_array`. It holds the synchronous-write, registered-read line storage: one port, write enable, index, write line, read line.
- The FSM, priority arbiter and latency counter live in `mem_line_server`.

## Test plan
- Preload line 5 = 128'hA5…; `iReadReq`, `iReadAddr`=0x50 → `iReadValid` pulses once exactly 10 cycles after sample, with `iReadData`=128'hA5….
- `wReq`, `wAddr`=0x60, `wLine`=128'h1234…; then `dReadReq`, `dReadAddr`=0x6C → `wAck` at +10, then `dReadValid` returns 128'h1234… (offset bits ignored).
- All three reqs asserted in the same cycle → order is `wAck`, then `dReadValid`, then `iReadValid`, responses 11 cycles apart, one pulse each.
- `dReadAddr`=0x4050 with MEM_LINES=1024 → returns line 5 (wrap-around).
- `rst` low 3 cycles into a write of 128'hFF… to line 7 → no `wAck`, line 7 keeps its old value, outputs 0; after release the held `wReq` completes 10 cycles after the first post-reset edge.
- LATENCY=1 build: `iReadReq` sampled at t → `iReadValid` during t+1; a req held through RESP is re-granted only once, not twice.
